sap_control_sequencer: RTL and testbench

Control sequencer for the SAP datapath: a six-state ring counter (T1–T6) plus instruction decoder. It drives the load/enable/ALU control word that moves data over the shared 8-bit bus (`bus_high`/`bus_low`). It sits beside the instruction register inside `top` and sequences fetch and execute for LDA, ADD, SUB, OUT and HLT. It guarantees at most one bus driver per cycle.

---
 rtl/sap_control_sequencer.sv | 172 +++++++++++++++++
 tb/tb_sap_control_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sap_control_sequencer.sv
// rtl/sap_control_sequencer.sv - SAP T1..T6 ring counter and instruction decoder driving the datapath control word
//
// Ports:
//   i_clk        system clock, rising-edge active
//   i_clr        synchronous active-high reset (back to T1, clears halt)
//   i_opcode     IR[7:4], only consulted in T4..T6
//   o_t_state    one-hot ring state, bit0 = T1 .. bit5 = T6
//   o_hlt        halted flag
//   o_cp         PC increment
//   o_ep         PC drives bus
//   o_lm         MAR load
//   o_ce         RAM drives bus
//   o_li         IR load
//   o_ei         IR[3:0] drives bus
//   o_la         accumulator load
//   o_ea         accumulator drives bus
//   o_su         ALU subtract select
//   o_eu         ALU drives bus
//   o_lb         B register load
//   o_lo         output register load

module sap_control_sequencer #(
    parameter logic [3:0] OP_LDA = 4'b0000,
    parameter logic [3:0] OP_ADD = 4'b0001,
    parameter logic [3:0] OP_SUB = 4'b0010,
    parameter logic [3:0] OP_OUT = 4'b1110,
    parameter logic [3:0] OP_HLT = 4'b1111
) (
    input  logic       i_clk,
    input  logic       i_clr,
    input  logic [3:0] i_opcode,
    output logic [5:0] o_t_state,
    output logic       o_hlt,
    output logic       o_cp,
    output logic       o_ep,
    output logic       o_lm,
    output logic       o_ce,
    output logic       o_li,
    output logic       o_ei,
    output logic       o_la,
    output logic       o_ea,
    output logic       o_su,
    output logic       o_eu,
    output logic       o_lb,
    output logic       o_lo
);

    typedef enum logic [5:0] {
        ST_T1 = 6'b000001,
        ST_T2 = 6'b000010,
        ST_T3 = 6'b000100,
        ST_T4 = 6'b001000,
        ST_T5 = 6'b010000,
        ST_T6 = 6'b100000
    } ring_e;

    ring_e r_ring;
    logic  r_hlt;

    logic  w_run;
    logic  w_is_lda;
    logic  w_is_add;
    logic  w_is_sub;
    logic  w_is_out;
    logic  w_is_hlt;
    logic  w_mem_op;
    ring_e w_ring_next;

    // Controls are only live when neither reset nor halt is in force, so a
    // clr cycle can never leak fetch or partial-execute controls.
    assign w_run = !i_clr && !r_hlt;

    assign w_is_lda = (i_opcode == OP_LDA);
    assign w_is_add = (i_opcode == OP_ADD);
    assign w_is_sub = (i_opcode == OP_SUB);
    assign w_is_out = (i_opcode == OP_OUT);
    assign w_is_hlt = (i_opcode == OP_HLT);

    // LDA, ADD and SUB share the T4 address phase (IR operand -> MAR).
    assign w_mem_op = w_is_lda || w_is_add || w_is_sub;

    always_comb begin
        w_ring_next = ST_T1;
        case (r_ring)
            ST_T1:   w_ring_next = ST_T2;
            ST_T2:   w_ring_next = ST_T3;
            ST_T3:   w_ring_next = ST_T4;
            ST_T4:   w_ring_next = ST_T5;
            ST_T5:   w_ring_next = ST_T6;
            ST_T6:   w_ring_next = ST_T1;
            // A corrupted (non one-hot) ring resynchronises to fetch.
            default: w_ring_next = ST_T1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_ring <= ST_T1;
            r_hlt  <= 1'b0;
        end else if (!r_hlt) begin
            if (r_ring == ST_T4 && w_is_hlt) begin
                // Freeze on T4; only clr leaves the halted state.
                r_hlt <= 1'b1;
            end else begin
                r_ring <= w_ring_next;
            end
        end
    end

    assign o_t_state = r_ring;
    assign o_hlt     = r_hlt;

    // Each state drives at most one of ep/ce/ei/ea/eu, so the shared bus
    // has a single source in every cycle, whatever the opcode.
    always_comb begin
        o_cp = 1'b0;
        o_ep = 1'b0;
        o_lm = 1'b0;
        o_ce = 1'b0;
        o_li = 1'b0;
        o_ei = 1'b0;
        o_la = 1'b0;
        o_ea = 1'b0;
        o_su = 1'b0;
        o_eu = 1'b0;
        o_lb = 1'b0;
        o_lo = 1'b0;
        if (w_run) begin
            case (r_ring)
                ST_T1: begin
                    o_ep = 1'b1;
                    o_lm = 1'b1;
                end
                ST_T2: begin
                    o_cp = 1'b1;
                end
                ST_T3: begin
                    o_ce = 1'b1;
                    o_li = 1'b1;
                end
                ST_T4: begin
                    if (w_mem_op) begin
                        o_ei = 1'b1;
                        o_lm = 1'b1;
                    end else if (w_is_out) begin
                        o_ea = 1'b1;
                        o_lo = 1'b1;
                    end
                end
                ST_T5: begin
                    if (w_is_lda) begin
                        o_ce = 1'b1;
                        o_la = 1'b1;
                    end else if (w_is_add || w_is_sub) begin
                        o_ce = 1'b1;
                        o_lb = 1'b1;
                    end
                end
                ST_T6: begin
                    if (w_is_add || w_is_sub) begin
                        o_eu = 1'b1;
                        o_la = 1'b1;
                        o_su = w_is_sub;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sap_control_sequencer.sv
// tb/tb_sap_control_sequencer.sv - randomized self-checking bench for sap_control_sequencer

module tb_sap_control_sequencer;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // Control word packing: {cp,ep,lm,ce,li,ei,la,ea,su,eu,lb,lo}
    localparam logic [11:0] K_CP = 12'h800;
    localparam logic [11:0] K_EP = 12'h400;
    localparam logic [11:0] K_LM = 12'h200;
    localparam logic [11:0] K_CE = 12'h100;
    localparam logic [11:0] K_LI = 12'h080;
    localparam logic [11:0] K_EI = 12'h040;
    localparam logic [11:0] K_LA = 12'h020;
    localparam logic [11:0] K_EA = 12'h010;
    localparam logic [11:0] K_SU = 12'h008;
    localparam logic [11:0] K_EU = 12'h004;
    localparam logic [11:0] K_LB = 12'h002;
    localparam logic [11:0] K_LO = 12'h001;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] opcode = 4'b0101;
    logic [5:0] t_state;
    logic       hlt, cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: instruction step 0..5 and halted flag.
    int m_step   = 0;
    bit m_halted = 1'b0;
    bit m_valid  = 1'b0;

    always #5 clk = ~clk;

    sap_control_sequencer #(
        .OP_LDA(OP_LDA), .OP_ADD(OP_ADD), .OP_SUB(OP_SUB),
        .OP_OUT(OP_OUT), .OP_HLT(OP_HLT)
    ) dut (
        .i_clk(clk), .i_clr(clr), .i_opcode(opcode),
        .o_t_state(t_state), .o_hlt(hlt),
        .o_cp(cp), .o_ep(ep), .o_lm(lm), .o_ce(ce), .o_li(li), .o_ei(ei),
        .o_la(la), .o_ea(ea), .o_su(su), .o_eu(eu), .o_lb(lb), .o_lo(lo)
    );

    function automatic logic [11:0] ctrl_word();
        return {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo};
    endfunction

    // Microcode table straight from the instruction timing rules.
    function automatic logic [11:0] micro(input int step, input logic [3:0] op);
        logic [11:0] w;
        w = 12'h000;
        if (step == 0) w = K_EP | K_LM;
        else if (step == 1) w = K_CP;
        else if (step == 2) w = K_CE | K_LI;
        else if (op == OP_LDA) w = (step == 3) ? (K_EI | K_LM) : (step == 4) ? (K_CE | K_LA) : 12'h000;
        else if (op == OP_ADD) w = (step == 3) ? (K_EI | K_LM) : (step == 4) ? (K_CE | K_LB) : (K_EU | K_LA);
        else if (op == OP_SUB) w = (step == 3) ? (K_EI | K_LM) : (step == 4) ? (K_CE | K_LB) : (K_EU | K_LA | K_SU);
        else if (op == OP_OUT) w = (step == 3) ? (K_EA | K_LO) : 12'h000;
        return w;
    endfunction

    always @(posedge clk) begin
        if (clr) begin
            m_step   <= 0;
            m_halted <= 1'b0;
            m_valid  <= 1'b1;
        end else if (m_valid && !m_halted) begin
            if (m_step == 3 && opcode == OP_HLT) m_halted <= 1'b1;
            else m_step <= (m_step + 1) % 6;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, act, exp, $time);
        end
    endtask

    // Compare the DUT against the model for the current cycle.
    task automatic compare_all();
        logic [11:0] exp;
        chk("bus_single_driver", 32'($countones({ep, ce, ei, ea, eu}) <= 1), 32'd1);
        if (clr) begin
            chk("ctrl_in_clr", 32'(ctrl_word()), 32'd0);
        end else if (m_valid) begin
            exp = m_halted ? 12'h000 : micro(m_step, opcode);
            chk("t_state", 32'(t_state), 32'(6'b1 << m_step));
            chk("hlt", 32'(hlt), 32'(m_halted));
            chk("ctrl", 32'(ctrl_word()), 32'(exp));
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then check.
    task automatic cycle(input logic c, input logic [3:0] op);
        @(negedge clk);
        clr = c;
        // opcode is meaningless during fetch; scramble it there.
        if (m_valid && !m_halted && m_step < 3 && !c) opcode = 4'($urandom_range(0, 15));
        else opcode = op;
        #1;
        compare_all();
    endtask

    task automatic run_instr(input logic [3:0] op);
        for (int i = 0; i < 6; i++) cycle(1'b0, op);
    endtask

    logic prev_clr;

    initial begin
        // Reset and free-run with an undefined opcode.
        cycle(1'b1, 4'b0101);
        cycle(1'b1, 4'b0101);
        chk("reset_t_state", 32'(t_state), 32'h01);
        chk("reset_hlt", 32'(hlt), 32'd0);
        cycle(1'b0, 4'b0101);
        chk("first_t1_ctrl", 32'(ctrl_word()), 32'h600);
        for (int i = 0; i < 11; i++) cycle(1'b0, 4'b0101);
        chk("nop_wrap_t6", 32'(t_state), 32'h20);
        chk("nop_t6_ctrl", 32'(ctrl_word()), 32'h000);

        run_instr(OP_ADD);
        chk("add_t6_literal", 32'(ctrl_word()), 32'h024);
        run_instr(OP_SUB);
        chk("sub_t6_literal", 32'(ctrl_word()), 32'h02C);
        run_instr(OP_LDA);
        chk("lda_t6_literal", 32'(ctrl_word()), 32'h000);
        for (int i = 0; i < 4; i++) cycle(1'b0, OP_OUT);
        chk("out_t4_literal", 32'(ctrl_word()), 32'h011);
        cycle(1'b0, OP_OUT);
        cycle(1'b0, OP_OUT);

        // HLT: freeze at T4 with everything quiet.
        for (int i = 0; i < 4; i++) cycle(1'b0, OP_HLT);
        chk("hlt_t4_quiet", 32'(ctrl_word()), 32'h000);
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 4'($urandom_range(0, 15)));
            chk("halt_hold_t4", 32'(t_state), 32'h08);
            chk("halt_flag", 32'(hlt), 32'd1);
        end
        cycle(1'b1, OP_HLT);
        chk("clr_while_halted_ctrl", 32'(ctrl_word()), 32'h000);
        cycle(1'b0, OP_ADD);
        chk("after_halt_t1", 32'(t_state), 32'h01);
        chk("after_halt_hlt", 32'(hlt), 32'd0);

        // Randomized opcodes with clr pulses at arbitrary T-states.
        prev_clr = 1'b0;
        for (int i = 0; i < 600; i++) begin
            logic       c;
            logic [3:0] op;
            int         sel;
            c   = ($urandom_range(0, 19) == 0);
            sel = $urandom_range(0, 7);
            case (sel)
                0: op = OP_LDA;
                1: op = OP_ADD;
                2: op = OP_SUB;
                3: op = OP_OUT;
                4: op = ($urandom_range(0, 3) == 0) ? OP_HLT : OP_ADD;
                default: op = 4'($urandom_range(3, 13));
            endcase
            // Keep opcode stable over an execute phase, like a real IR.
            if (m_step >= 3 && m_step <= 5 && i > 0) op = opcode;
            cycle(c, op);
            if (prev_clr) chk("t1_after_clr", 32'(t_state), 32'h01);
            prev_clr = c;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
